// File: rtl/render_frame_sequencer.sv
// Per-frame sequencer: latches camera, builds the Q16.16 view matrix, clears depth, kicks the rasterizer, swaps on sync.
// Optional depth-buffer clear pass is compiled in with the DEPTH_CLEAR_EN macro.
module render_frame_sequencer #(
  parameter int COORD_WIDTH   = 32,
  parameter int FB_ADDR_WIDTH = 17,
  parameter int FB_DEPTH      = 76800
) (
  input  logic                                       clk_in,
  input  logic                                       rst_in,
  input  logic                                       frame_sync_in,
  input  logic signed [COORD_WIDTH-1:0]              cam_x_in,
  input  logic signed [COORD_WIDTH-1:0]              cam_y_in,
  input  logic signed [COORD_WIDTH-1:0]              cam_z_in,
  input  logic                                       cam_valid_in,
  input  logic                                       rast_done_in,
  output logic                                       rast_start_out,
  output logic signed [COORD_WIDTH-1:0]              rast_x_out,
  output logic signed [COORD_WIDTH-1:0]              rast_y_out,
  output logic signed [COORD_WIDTH-1:0]              rast_z_out,
  output logic signed [3:0][3:0][COORD_WIDTH-1:0]    view_matrix_out,
  output logic                                       clr_we_out,
  output logic        [FB_ADDR_WIDTH-1:0]            clr_addr_out,
  output logic                                       swap_out,
  output logic                                       busy_out,
  output logic        [15:0]                         frames_dropped_out
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_CLEAR     = 3'd1;
  localparam logic [2:0] S_START     = 3'd2;
  localparam logic [2:0] S_RENDER    = 3'd3;
  localparam logic [2:0] S_WAIT_SWAP = 3'd4;

`ifdef DEPTH_CLEAR_EN
  localparam logic [2:0] S_FIRST = S_CLEAR;
  localparam logic [FB_ADDR_WIDTH-1:0] LAST_ADDR = FB_ADDR_WIDTH'(FB_DEPTH - 1);
`else
  localparam logic [2:0] S_FIRST = S_START;
`endif

  localparam logic signed [COORD_WIDTH-1:0] Q_ONE = COORD_WIDTH'(65536);

  logic [2:0]  state_q, state_d;
  logic [15:0] dropped_q, dropped_d;
  logic        start_q, start_d;
  logic        swap_q, swap_d;
  logic        busy_q, busy_d;
  logic        frame_start, drop_inc;
  logic signed [2:0][COORD_WIDTH-1:0] shadow_q, shadow_d;
  logic signed [2:0][COORD_WIDTH-1:0] active_q, active_d;
`ifdef DEPTH_CLEAR_EN
  logic                     clr_we_q, clr_we_d;
  logic [FB_ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;
`endif

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d     = state_q;
    dropped_d   = dropped_q;
    swap_d      = 1'b0;
    frame_start = 1'b0;
    drop_inc    = 1'b0;
`ifdef DEPTH_CLEAR_EN
    clr_addr_d  = '0;
`endif
    case (state_q)
      S_IDLE: begin
        if (frame_sync_in) begin
          frame_start = 1'b1;
          state_d     = S_FIRST;
        end
      end
`ifdef DEPTH_CLEAR_EN
      S_CLEAR: begin
        drop_inc = frame_sync_in;
        if (clr_addr_q == LAST_ADDR) state_d = S_START;
        else                         clr_addr_d = clr_addr_q + 1'b1;
      end
`endif
      S_START: begin
        drop_inc = frame_sync_in;
        state_d  = S_RENDER;
      end
      S_RENDER: begin
        // A sync arriving with done is still a drop; the swap waits for the next sync.
        drop_inc = frame_sync_in;
        if (rast_done_in) state_d = S_WAIT_SWAP;
      end
      S_WAIT_SWAP: begin
        if (frame_sync_in) begin
          frame_start = 1'b1;
          swap_d      = 1'b1;
          state_d     = S_FIRST;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (drop_inc && dropped_q != 16'hFFFF) dropped_d = dropped_q + 16'd1;

    // Shadow feeds active through the same cycle so a coincident cam_valid is bypassed.
    shadow_d = cam_valid_in ? {cam_z_in, cam_y_in, cam_x_in} : shadow_q;
    active_d = frame_start ? shadow_d : active_q;

    start_d  = (state_d == S_START);
    busy_d   = (state_d != S_IDLE);
`ifdef DEPTH_CLEAR_EN
    clr_we_d = (state_d == S_CLEAR);
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= S_IDLE;
      dropped_q  <= '0;
      start_q    <= 1'b0;
      swap_q     <= 1'b0;
      busy_q     <= 1'b0;
      shadow_q   <= '0;
      active_q   <= '0;
`ifdef DEPTH_CLEAR_EN
      clr_we_q   <= 1'b0;
      clr_addr_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      dropped_q  <= dropped_d;
      start_q    <= start_d;
      swap_q     <= swap_d;
      busy_q     <= busy_d;
      shadow_q   <= shadow_d;
      active_q   <= active_d;
`ifdef DEPTH_CLEAR_EN
      clr_we_q   <= clr_we_d;
      clr_addr_q <= clr_addr_d;
`endif
    end
  end

  always_comb begin
    view_matrix_out = '0;
    for (int i = 0; i < 4; i++) view_matrix_out[i][i] = Q_ONE;
    view_matrix_out[0][3] = active_q[0];
    view_matrix_out[1][3] = active_q[1];
    view_matrix_out[2][3] = active_q[2];
  end

  assign rast_start_out     = start_q;
  assign swap_out           = swap_q;
  assign busy_out           = busy_q;
  assign frames_dropped_out = dropped_q;
  assign rast_x_out         = active_q[0];
  assign rast_y_out         = active_q[1];
  assign rast_z_out         = active_q[2];
`ifdef DEPTH_CLEAR_EN
  assign clr_we_out         = clr_we_q;
  assign clr_addr_out       = clr_addr_q;
`else
  assign clr_we_out         = 1'b0;
  assign clr_addr_out       = '0;
`endif

endmodule

// File: tb/tb_render_frame_sequencer.sv
// Scoreboard bench for render_frame_sequencer; adapts its expected event trace to DEPTH_CLEAR_EN.
module tb_render_frame_sequencer;

  localparam int CW    = 32;
  localparam int AW    = 17;
  localparam int DEPTH = 16;
`ifdef DEPTH_CLEAR_EN
  localparam bit CLR_EN = 1'b1;
`else
  localparam bit CLR_EN = 1'b0;
`endif

  typedef struct packed {
    logic          clr;
    logic          start;
    logic          swap;
    logic [AW-1:0] addr;
  } evt_t;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  logic frame_sync_in = 1'b0, cam_valid_in = 1'b0, rast_done_in = 1'b0;
  logic signed [CW-1:0] cam_x_in = '0, cam_y_in = '0, cam_z_in = '0;
  logic rast_start_out, clr_we_out, swap_out, busy_out;
  logic signed [CW-1:0] rast_x_out, rast_y_out, rast_z_out;
  logic signed [3:0][3:0][CW-1:0] view_matrix_out;
  logic [AW-1:0] clr_addr_out;
  logic [15:0]   frames_dropped_out;

  int   vectors = 0;
  int   miscompares = 0;
  evt_t exp_q[$];

  render_frame_sequencer #(.COORD_WIDTH(CW), .FB_ADDR_WIDTH(AW), .FB_DEPTH(DEPTH)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .frame_sync_in(frame_sync_in),
    .cam_x_in(cam_x_in), .cam_y_in(cam_y_in), .cam_z_in(cam_z_in),
    .cam_valid_in(cam_valid_in), .rast_done_in(rast_done_in),
    .rast_start_out(rast_start_out), .rast_x_out(rast_x_out), .rast_y_out(rast_y_out),
    .rast_z_out(rast_z_out), .view_matrix_out(view_matrix_out), .clr_we_out(clr_we_out),
    .clr_addr_out(clr_addr_out), .swap_out(swap_out), .busy_out(busy_out),
    .frames_dropped_out(frames_dropped_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Monitor: every cycle showing clear, start or swap must match the next expected event.
  always @(negedge clk_in) begin
    if (!rst_in && (clr_we_out || rast_start_out || swap_out)) begin
      evt_t got;
      got = '{clr: clr_we_out, start: rast_start_out, swap: swap_out,
              addr: clr_we_out ? clr_addr_out : '0};
      if (exp_q.size() == 0) check("unexpected_event", 64'(got), 64'd0);
      else                   check("event", 64'(got), 64'(exp_q.pop_front()));
    end
  end

  task automatic push_frame(input logic swap);
    if (CLR_EN) begin
      for (int i = 0; i < DEPTH; i++)
        exp_q.push_back('{clr: 1'b1, start: 1'b0, swap: (i == 0) ? swap : 1'b0, addr: AW'(i)});
      exp_q.push_back('{clr: 1'b0, start: 1'b1, swap: 1'b0, addr: '0});
    end else begin
      exp_q.push_back('{clr: 1'b0, start: 1'b1, swap: swap, addr: '0});
    end
  endtask

  task automatic pulse(input logic s, input logic d, input logic v);
    @(posedge clk_in); #1;
    frame_sync_in = s; rast_done_in = d; cam_valid_in = v;
    @(posedge clk_in); #1;
    frame_sync_in = 0; rast_done_in = 0; cam_valid_in = 0;
  endtask

  task automatic wait_drain();
    bit done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk_in); #1;
      if (exp_q.size() == 0) done = 1;
    end
    if (!done) begin
      check("drain_timeout", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk_in);
    #1;
  endtask

  // Right after a sync is sampled the first event of the new frame must be on the outputs.
  task automatic check_first(input string name, input logic swap);
    @(negedge clk_in);
    check(name, {60'd0, clr_we_out, rast_start_out, swap_out, 1'b0}, {60'd0, CLR_EN, !CLR_EN, swap, 1'b0});
  endtask

  initial begin
    // Reset state: all outputs low, identity view matrix.
    #12;
    check("rst_outs", {60'd0, rast_start_out, clr_we_out, swap_out, busy_out}, 64'd0);
    check("rst_dropped", 64'(frames_dropped_out), 64'd0);
    check("rst_diag", {view_matrix_out[0][0], view_matrix_out[3][3]}, {32'h00010000, 32'h00010000});
    check("rst_col3", {view_matrix_out[0][3], view_matrix_out[2][3]}, 64'd0);
    @(posedge clk_in); #1 rst_in = 0;

    // Frame 1: camera load, matrix must not change until the sync.
    cam_x_in = 32'hFFFF0628; cam_y_in = 32'hFFFFF156; cam_z_in = 32'hFFFEC464;
    pulse(0, 0, 1);
    check("shadow_not_active", 64'(view_matrix_out[0][3]), 64'd0);
    push_frame(0);
    pulse(1, 0, 0);
    check_first("first_latency", 0);
    wait_drain();
    check("m03", 64'(view_matrix_out[0][3]), 64'h00000000FFFF0628);
    check("m13_m23", {view_matrix_out[1][3], view_matrix_out[2][3]}, {32'hFFFFF156, 32'hFFFEC464});
    check("m_diag", {view_matrix_out[1][1], view_matrix_out[2][2]}, {32'h00010000, 32'h00010000});
    check("busy_render", 64'(busy_out), 64'd1);

    // Done 40 cycles after start, then sync: swap one cycle later with the new frame.
    repeat (39) @(posedge clk_in);
    pulse(0, 1, 0);
    idle_cycles(4);
    push_frame(1);
    pulse(1, 0, 0);
    check_first("swap_latency", 1);
    wait_drain();
    check("no_drop", 64'(frames_dropped_out), 64'd0);

    // Two syncs during RENDER are dropped, nothing restarts.
    pulse(1, 0, 0);
    pulse(1, 0, 0);
    idle_cycles(3);
    check("drop2", 64'(frames_dropped_out), 64'd2);
    pulse(0, 1, 0);
    idle_cycles(5);
    check("busy_wait_swap", 64'(busy_out), 64'd1);
    push_frame(1);
    pulse(1, 0, 0);
    wait_drain();

    // Done and sync together in RENDER: dropped, then wait for the next sync.
    pulse(1, 1, 0);
    idle_cycles(6);
    check("drop3", 64'(frames_dropped_out), 64'd3);
    check("no_swap_same_cycle", 64'(swap_out), 64'd0);
    push_frame(1);
    pulse(1, 0, 0);
    wait_drain();

    // Reset in the middle of work (at clear address 7 when the clear exists).
    pulse(0, 1, 0);
    idle_cycles(2);
    if (CLR_EN) begin
      for (int i = 0; i < 8; i++)
        exp_q.push_back('{clr: 1'b1, start: 1'b0, swap: (i == 0), addr: AW'(i)});
    end else begin
      push_frame(1);
    end
    pulse(1, 0, 0);
    wait_drain();
    if (CLR_EN) check("at_addr7", 64'(clr_addr_out), 64'd7);
    rst_in = 1; #1;
    check("mid_rst_outs", {60'd0, rast_start_out, clr_we_out, swap_out, busy_out}, 64'd0);
    check("mid_rst_addr_drop", {clr_addr_out, frames_dropped_out}, 64'd0);
    check("mid_rst_matrix", {view_matrix_out[0][3], view_matrix_out[1][1]}, {32'd0, 32'h00010000});
    @(posedge clk_in); @(posedge clk_in); #1 rst_in = 0;
    pulse(0, 1, 0);
    idle_cycles(5);
    check("stray_done_idle", 64'(busy_out), 64'd0);

    // Bypass: cam_valid with the sync goes straight to active; a sync right after is dropped.
    cam_x_in = 32'h00020000; cam_y_in = 32'hFFFE8000; cam_z_in = 32'h00001234;
    push_frame(0);
    pulse(1, 0, 1);
    pulse(1, 0, 0);
    wait_drain();
    check("bypass_x", 64'(rast_x_out), 64'h0000000000020000);
    check("bypass_m13_m23", {view_matrix_out[1][3], view_matrix_out[2][3]}, {32'hFFFE8000, 32'h00001234});
    check("drop_after_rst", 64'(frames_dropped_out), 64'd1);
    idle_cycles(10);
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
